// File: rtl/serializer_tx_arbiter_if.sv
// Requester/serializer-facing bundle for serializer_tx_arbiter.
// The slave modport is the arbiter; master is the surrounding environment.
interface serializer_tx_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DATA_W = 16
);
  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        ack;
  logic                   ser_start;
  logic [DATA_W-1:0]      ser_data;
  logic                   ser_idle;
  logic                   busy;
  logic [1:0]             grant_id;
  logic                   err_timeout;
  logic                   err_clr;

  modport master (
    output req, req_data, ser_idle, err_clr,
    input  ack, ser_start, ser_data, busy, grant_id, err_timeout
  );

  modport slave (
    input  req, req_data, ser_idle, err_clr,
    output ack, ser_start, ser_data, busy, grant_id, err_timeout
  );
endinterface

// File: rtl/serializer_tx_arbiter.sv
// Round-robin arbiter sharing one serializer among four requesters, with an
// ack on frame completion and a sticky watchdog for frames that never finish.
module serializer_tx_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TMO_W  = 8
) (
  input logic               clock,
  input logic               resetn,
  serializer_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StBusy, StDone} state_e;

  localparam logic [TMO_W-1:0] WdogMax = '1;
  localparam logic [TMO_W-1:0] WdogPre = WdogMax - 1'b1;

  state_e            state_q;
  logic [1:0]        ptr_q;
  logic [NREQ-1:0]   mask_q;
  logic [TMO_W-1:0]  wdog_q;
  logic [NREQ-1:0]   ack_q;
  logic              start_q;
  logic [DATA_W-1:0] data_q;
  logic              busy_q;
  logic [1:0]        grant_q;
  logic              err_q;

  logic [NREQ-1:0]   eligible;
  logic              found;
  logic [1:0]        winner;
  logic [1:0]        idx;
  logic              in_frame;
  logic              wd_set;

  // First set bit of eligible, searching upward from the pointer with wrap.
  always_comb begin
    eligible = bus.req & ~mask_q;
    found    = 1'b0;
    winner   = ptr_q;
    idx      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign in_frame = (state_q == StIssue) || (state_q == StBusy);
  assign wd_set   = in_frame && (wdog_q == WdogPre);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      mask_q  <= '0;
      wdog_q  <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      grant_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= '0;
      // Set has priority over a coincident clear.
      if (wd_set) begin
        err_q <= 1'b1;
      end else if (bus.err_clr) begin
        err_q <= 1'b0;
      end
      if (in_frame && (wdog_q != WdogMax)) begin
        wdog_q <= wdog_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          mask_q <= '0;
          if (found) begin
            grant_q <= winner;
            data_q  <= bus.req_data[winner*DATA_W +: DATA_W];
            wdog_q  <= '0;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (!bus.ser_idle) begin
            start_q <= 1'b0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (bus.ser_idle) begin
            ack_q[grant_q] <= 1'b1;
            state_q        <= StDone;
          end
        end
        StDone: begin
          // Mask hides the just-served requester's residual req for one cycle.
          ptr_q   <= grant_q + 2'd1;
          mask_q  <= NREQ'(1) << grant_q;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ack         = ack_q;
  assign bus.ser_start   = start_q;
  assign bus.ser_data    = data_q;
  assign bus.busy        = busy_q;
  assign bus.grant_id    = grant_q;
  assign bus.err_timeout = err_q;

endmodule
